// File: rtl/tick_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tick_sched_ctrl
//
// Single-clock run controller for the counter experiment's timebase. An
// internal prescaler issues a one-cycle `tick` enable every DIV cycles of
// clk_in while the run state machine is in RUN, and each tick advances a
// bounded event count. Downstream logic stays on clk_in and uses `tick` as
// a clock enable.
//
// Optional feature macro: TICK_SCHED_AUTORELOAD_EN
//   defined     - the terminal tick wraps `count` to 0 and stays in RUN;
//                 DONE is never entered and `done` is tied to 0.
//   not defined - the terminal tick parks the block in DONE with `count`
//                 holding CNT_MAX until `start` or `clear`.
//
// Parameters:
//   DIV      clk_in cycles per tick (>= 2)
//   CNT_W    width of `count`
//   CNT_MAX  terminal count (< 2**CNT_W)
//
// Ports:
//   clk_in   in   the only clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   pulse: start / resume the run
//   pause    in   pulse: freeze the run
//   clear    in   pulse: abort and zero the block (highest priority)
//   tick     out  registered one-cycle enable
//   count    out  registered event count
//   state    out  current state: IDLE=0, RUN=1, PAUSE=2, DONE=3
//   running  out  registered, high while in RUN
//   done     out  registered, high while in DONE
//
// The control inputs are level-sampled every cycle (no edge detection);
// there is no valid/ready handshake on this block.
// ---------------------------------------------------------------------------
module tick_sched_ctrl #(
    parameter int DIV     = 100,
    parameter int CNT_W   = 8,
    parameter int CNT_MAX = 59
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state,
    output logic             running,
    output logic             done
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [PRE_W-1:0]   pre_q,     pre_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               tick_q,    tick_d;
    logic               running_q, running_d;
    logic               done_q,    done_d;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        count_d = count_q;
        tick_d  = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                    end
                end
                ST_RUN: begin
                    // pause beats a pending tick: pre stays at DIV-1 so the
                    // tick fires on the first RUN edge after resume.
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (count_q == CNT_LAST) begin
`ifdef TICK_SCHED_AUTORELOAD_EN
                            count_d = '0;
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    // Resume keeps the prescaler phase.
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
`ifdef TICK_SCHED_AUTORELOAD_EN
        done_d    = 1'b0;
`else
        done_d    = (state_d == ST_DONE);
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign tick    = tick_q;
    assign count   = count_q;
    assign state   = state_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
